// File: rtl/mem_access_stage.sv
// MEM pipeline stage: Lw/Sw over a req/ack data port with timeout and alignment checks.
// Optional LL/SC support is enabled by defining LLBIT_EN.
module mem_access_stage #(
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  op_i,
   input  logic [31:0] regcData_i,
   input  logic        regcWrite_i,
   input  logic [4:0]  regcAddr_i,
   input  logic [31:0] memAddr_i,
   input  logic [31:0] memData_i,
   input  logic [31:0] excptype_i,
   input  logic [31:0] pc_i,
   input  logic        flush,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata,
   input  logic        dm_ack,
   output logic        stall,
   output logic [31:0] regData,
   output logic        regWrite,
   output logic [4:0]  regAddr,
   output logic [31:0] excptype_o,
   output logic [31:0] pc_o,
   output logic        llbit_o
);

   localparam logic [5:0] OP_LW = 6'h23;
   localparam logic [5:0] OP_SW = 6'h2b;
   localparam logic [7:0] LAST  = 8'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t      state;
   logic [7:0]  cnt;
   logic [31:0] rdata_q;
   logic        bus_err;
   logic        llbit;

   logic is_ll, is_sc;
   logic is_load, is_store, sc_fail;
   logic mem_op, no_exc, misalign, access;

`ifdef LLBIT_EN
   localparam logic [5:0] OP_LL = 6'h30;
   localparam logic [5:0] OP_SC = 6'h38;
   assign is_ll = (op_i == OP_LL);
   assign is_sc = (op_i == OP_SC);
`else
   assign is_ll = 1'b0;
   assign is_sc = 1'b0;
`endif

   assign is_load  = (op_i == OP_LW) | is_ll;
   assign is_store = (op_i == OP_SW) | (is_sc & llbit);
   assign sc_fail  = is_sc & ~llbit;
   assign mem_op   = is_load | is_store;
   assign no_exc   = (excptype_i == 32'h0);
   assign misalign = mem_op & no_exc & (|memAddr_i[1:0]);
   assign access   = mem_op & no_exc & ~(|memAddr_i[1:0]) & ~flush;

   assign regAddr = regcAddr_i;
   assign pc_o    = pc_i;
   assign llbit_o = llbit;

   always_comb begin
      stall = 1'b0;
      case (state)
         IDLE:    stall = access;
         WAIT:    stall = 1'b1;
         default: stall = 1'b0;
      endcase
   end

   always_comb begin
      regData    = regcData_i;
      regWrite   = regcWrite_i;
      excptype_o = excptype_i;
      case (state)
         IDLE: begin
            if (mem_op | sc_fail) begin
               regWrite = 1'b0;
               if (no_exc) begin
                  if (sc_fail) begin
                     regData  = 32'h0;
                     regWrite = 1'b1;
                  end else if (misalign) begin
                     excptype_o = is_store ? 32'h0000_0014 : 32'h0000_0010;
                  end
               end
            end
         end
         WAIT: regWrite = 1'b0;
         default: begin
            if (bus_err) begin
               regWrite   = 1'b0;
               excptype_o = 32'h0000_1000;
            end else if (is_sc) begin
               regData  = 32'h1;
               regWrite = 1'b1;
            end else if (is_load) begin
               regData = rdata_q;
            end else begin
               regWrite = 1'b0;
            end
         end
      endcase
      if (flush) regWrite = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= 8'h0;
         rdata_q  <= 32'h0;
         bus_err  <= 1'b0;
         dm_req   <= 1'b0;
         dm_we    <= 1'b0;
         dm_addr  <= 32'h0;
         dm_wdata <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               bus_err <= 1'b0;
               if (access) begin
                  state    <= WAIT;
                  cnt      <= 8'h0;
                  dm_req   <= 1'b1;
                  dm_we    <= is_store;
                  dm_addr  <= {memAddr_i[31:2], 2'b00};
                  dm_wdata <= memData_i;
               end
            end
            WAIT: begin
               if (flush) begin
                  dm_req <= 1'b0;
                  state  <= IDLE;
               end else if (dm_ack) begin
                  rdata_q <= dm_rdata;
                  dm_req  <= 1'b0;
                  state   <= DONE;
               end else if (cnt == LAST) begin
                  dm_req  <= 1'b0;
                  bus_err <= 1'b1;
                  state   <= DONE;
               end else begin
                  cnt <= cnt + 8'h1;
               end
            end
            default: begin
               state   <= IDLE;
               bus_err <= 1'b0;
            end
         endcase
      end
   end

`ifdef LLBIT_EN
   // any reported exception, Eret included, breaks the LL/SC reservation
   always_ff @(posedge clk) begin
      if (rst) begin
         llbit <= 1'b0;
      end else if (excptype_o != 32'h0) begin
         llbit <= 1'b0;
      end else if (state == DONE && !flush) begin
         if (is_ll)      llbit <= 1'b1;
         else if (is_sc) llbit <= 1'b0;
      end
   end
`else
   assign llbit = 1'b0;
`endif

endmodule
